// File: rtl/fp_product_accumulator.sv
// Sequential single-precision accumulator: align/add/normalize FSM with truncation and flush-to-zero.
// Optional build macro FP_ACC_SAT_EN saturates overflowing results to infinity instead of wrapping the exponent.
`timescale 1ns/1ps
module fp_product_accumulator #(
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic [2:0]  dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready are both high;
  // a source holds its payload stable while valid is high and ready is low.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    ADD    = 3'd2,
    NORM   = 3'd3,
    COMMIT = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t state, state_next;

  logic [31:0] acc;
  logic [31:0] x;
  logic        last;
  logic [31:0] result;
  logic [23:0] man_a;
  logic [23:0] man_x;
  logic [23:0] mant;
  logic [8:0]  wexp;
  logic        wsign;
  logic        ovf;
  logic        udf;

  // ALIGN helpers
  logic [7:0]  exp_a;
  logic [7:0]  exp_x;
  logic        x_bigger;
  logic [7:0]  exp_diff;
  logic        zero_path;
  logic [23:0] full_a;
  logic [23:0] full_x;
  logic [23:0] shifted_small;

  // ADD helpers
  logic [24:0] add_sum;
  logic        add_sign;
  logic [23:0] add_mant;
  logic [8:0]  add_exp;
  logic        add_ovf;
  logic        sat_bypass;

  assign exp_a     = acc[30:23];
  assign exp_x     = x[30:23];
  assign x_bigger  = (exp_x >= exp_a);
  assign exp_diff  = x_bigger ? (exp_x - exp_a) : (exp_a - exp_x);
  assign zero_path = (exp_x == 8'd0) || (exp_a == 8'd0);
  assign full_a    = {1'b1, acc[22:0]};
  assign full_x    = {1'b1, x[22:0]};

  // Bits shifted past the LSB are simply dropped; 24+ positions empties the mantissa.
  always_comb begin
    shifted_small = 24'd0;
    if (exp_diff < 8'd24) begin
      shifted_small = x_bigger ? (full_a >> exp_diff) : (full_x >> exp_diff);
    end
  end

  always_comb begin
    add_sum  = 25'd0;
    add_sign = 1'b0;
    if (acc[31] == x[31]) begin
      add_sum  = {1'b0, man_a} + {1'b0, man_x};
      add_sign = x[31];
    end else if (man_a > man_x) begin
      add_sum  = {1'b0, man_a} - {1'b0, man_x};
      add_sign = acc[31];
    end else if (man_x > man_a) begin
      add_sum  = {1'b0, man_x} - {1'b0, man_a};
      add_sign = x[31];
    end
  end

  assign add_mant = add_sum[24] ? add_sum[24:1] : add_sum[23:0];
  assign add_exp  = wexp + {8'd0, add_sum[24]};
  assign add_ovf  = (add_exp >= 9'd255);

`ifdef FP_ACC_SAT_EN
  assign sat_bypass = add_ovf;
`else
  assign sat_bypass = 1'b0;
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ALIGN;
      end
      ALIGN:  state_next = zero_path ? COMMIT : ADD;
      ADD:    state_next = sat_bypass ? COMMIT : NORM;
      NORM: begin
        if ((mant == 24'd0) || mant[23] || (wexp == 9'd1)) state_next = COMMIT;
      end
      COMMIT: state_next = last ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state     = state;
  assign out_overflow  = ovf;
  assign out_underflow = udf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= ACC_INIT;
      x        <= 32'd0;
      last     <= 1'b0;
      result   <= 32'd0;
      man_a    <= 24'd0;
      man_x    <= 24'd0;
      mant     <= 24'd0;
      wexp     <= 9'd0;
      wsign    <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      out_data <= ACC_INIT;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x    <= in_data;
            last <= in_last;
          end
        end
        ALIGN: begin
          if (exp_x == 8'd0) begin
            result <= acc;
          end else if (exp_a == 8'd0) begin
            result <= x;
          end else begin
            man_a <= x_bigger ? shifted_small : full_a;
            man_x <= x_bigger ? full_x : shifted_small;
            wexp  <= {1'b0, (x_bigger ? exp_x : exp_a)};
          end
        end
        ADD: begin
          mant  <= add_mant;
          wexp  <= add_exp;
          wsign <= add_sign;
          if (add_ovf) ovf <= 1'b1;
          if (sat_bypass) result <= {add_sign, 8'hFF, 23'd0};
        end
        NORM: begin
          if (mant == 24'd0) begin
            result <= 32'd0;
          end else if (mant[23]) begin
            // Non-saturating build: an exponent of 256+ keeps only its low 8 bits.
            result <= {wsign, wexp[7:0], mant[22:0]};
          end else begin
            mant <= {mant[22:0], 1'b0};
            wexp <= wexp - 9'd1;
            if (wexp == 9'd1) begin
              result <= 32'd0;
              udf    <= 1'b1;
            end
          end
        end
        COMMIT: begin
          acc <= result;
          if (last) out_data <= result;
        end
        OUT: begin
          if (out_ready) begin
            acc <= ACC_INIT;
            ovf <= 1'b0;
            udf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_product_accumulator.sv
// Directed bench for fp_product_accumulator: hand-computed sums, latencies, stall and mid-operation reset.
`timescale 1ns/1ps
module tb_fp_product_accumulator;

  localparam logic [31:0] ACC_INIT = 32'h0000_0000;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_ADD   = 3'd2;
  localparam logic [2:0]  ST_NORM  = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_overflow;
  logic        out_underflow;
  logic [2:0]  dbg_state;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  fp_product_accumulator #(.ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .dbg_state(dbg_state)
  );

  // driver: offers one element, returns accept-to-ready/valid latency and NORM cycle count
  task automatic send(input logic [31:0] d, input logic l, output int lat, output int norm_n, output bit to);
    int n;
    to = 1'b0; lat = 0; norm_n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    lat = 1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready || out_valid) break;
      if (dbg_state == ST_NORM) norm_n++;
      @(posedge clk);
      lat++;
      n++;
    end
    if (!(in_ready || out_valid)) to = 1'b1;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== ACC_INIT) $display("FAIL reset_out_data: got %h want %h", out_data, ACC_INIT); else passed++;
    checks++; if ({out_overflow, out_underflow} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {out_overflow, out_underflow}); else passed++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_add_simple();
    int lat, nrm; bit to; logic [31:0] e;
    send(32'h3F80_0000, 1'b0, lat, nrm, to);
    checks++; if (to) $display("FAIL simple_first_timeout: got timeout want ready"); else passed++;
    send(32'h4000_0000, 1'b1, lat, nrm, to);
    exp_q.push_back(32'h4040_0000);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL simple_sum: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    checks++; if ({out_overflow, out_underflow} !== 2'b00) $display("FAIL simple_flags: got %b want 00", {out_overflow, out_underflow}); else passed++;
    checks++; if (lat != 5) $display("FAIL simple_latency: got %0d want 5", lat); else passed++;
    handshake();
  endtask

  task automatic test_cancel();
    int lat, nrm; bit to; logic [31:0] e;
    send(32'h3F80_0000, 1'b0, lat, nrm, to);
    send(32'hBF80_0000, 1'b1, lat, nrm, to);
    exp_q.push_back(32'h0000_0000);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL cancel_sum: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    checks++; if ({out_overflow, out_underflow} !== 2'b00) $display("FAIL cancel_flags: got %b want 00", {out_overflow, out_underflow}); else passed++;
    handshake();
  endtask

  task automatic test_norm_shift();
    int lat, nrm; bit to; logic [31:0] e;
    send(32'h3F80_0000, 1'b0, lat, nrm, to);
    send(32'hBF40_0000, 1'b1, lat, nrm, to);
    exp_q.push_back(32'h3E80_0000);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL norm_sum: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    checks++; if (nrm != 3) $display("FAIL norm_cycles: got %0d want 3", nrm); else passed++;
    checks++; if (lat != 7) $display("FAIL norm_latency: got %0d want 7", lat); else passed++;
    handshake();
  endtask

  task automatic test_overflow();
    int lat, nrm; bit to; logic [31:0] e;
    int exp_lat;
`ifdef FP_ACC_SAT_EN
    exp_q.push_back(32'h7F80_0000);
    exp_lat = 4;
`else
    exp_q.push_back(32'h7FFF_FFFF);
    exp_lat = 5;
`endif
    send(32'h7F7F_FFFF, 1'b0, lat, nrm, to);
    send(32'h7F7F_FFFF, 1'b1, lat, nrm, to);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL ovf_sum: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    checks++; if (out_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", out_overflow); else passed++;
    checks++; if (out_underflow !== 1'b0) $display("FAIL ovf_udf_flag: got %b want 0", out_underflow); else passed++;
    checks++; if (lat != exp_lat) $display("FAIL ovf_latency: got %0d want %0d", lat, exp_lat); else passed++;
    handshake();
    @(negedge clk);
    checks++; if (out_overflow !== 1'b0) $display("FAIL ovf_flag_cleared: got %b want 0", out_overflow); else passed++;
  endtask

  task automatic test_underflow();
    int lat, nrm; bit to; logic [31:0] e;
    send(32'h0080_0000, 1'b0, lat, nrm, to);
    send(32'h80C0_0000, 1'b1, lat, nrm, to);
    exp_q.push_back(32'h0000_0000);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL udf_sum: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    checks++; if (out_underflow !== 1'b1) $display("FAIL udf_flag: got %b want 1", out_underflow); else passed++;
    checks++; if (out_overflow !== 1'b0) $display("FAIL udf_ovf_flag: got %b want 0", out_overflow); else passed++;
    handshake();
  endtask

  task automatic test_zero_path();
    int lat, nrm; bit to; logic [31:0] e;
    send(32'h4000_0000, 1'b0, lat, nrm, to);
    checks++; if (to || lat != 3) $display("FAIL zero_acc_latency: got %0d (to=%0b) want 3", lat, to); else passed++;
    send(32'h0000_0000, 1'b1, lat, nrm, to);
    checks++; if (to || lat != 3) $display("FAIL zero_x_latency: got %0d (to=%0b) want 3", lat, to); else passed++;
    exp_q.push_back(32'h4000_0000);
    e = exp_q.pop_front();
    checks++; if (out_data !== e) $display("FAIL zero_sum: got %h want %h", out_data, e); else passed++;
    handshake();
  endtask

  task automatic test_stall();
    int lat, nrm; bit to; logic [31:0] e;
    send(32'h3F80_0000, 1'b0, lat, nrm, to);
    send(32'h4000_0000, 1'b1, lat, nrm, to);
    checks++; if (to || out_valid !== 1'b1) $display("FAIL stall_valid_start: got %b (to=%0b) want 1", out_valid, to); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h4040_0000 || in_ready !== 1'b0)
        $display("FAIL stall_cycle%0d: got valid=%b data=%h ready=%b want 1/40400000/0", i, out_valid, out_data, in_ready);
      else passed++;
    end
    handshake();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL stall_valid_drop: got %b want 0", out_valid); else passed++;
    send(32'h3F80_0000, 1'b1, lat, nrm, to);
    exp_q.push_back(32'h3F80_0000);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL stall_cleared_acc: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    handshake();
  endtask

  task automatic test_reset_midop();
    int lat, nrm, n; bit to; logic [31:0] e;
    send(32'h3F80_0000, 1'b0, lat, nrm, to);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h4000_0000; in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    while (dbg_state != ST_ADD && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (dbg_state !== ST_ADD) $display("FAIL midop_reach_add: got %0d want %0d", dbg_state, ST_ADD); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midop_handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
    checks++; if (out_data !== ACC_INIT) $display("FAIL midop_out_data: got %h want %h", out_data, ACC_INIT); else passed++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL midop_state: got %0d want %0d", dbg_state, ST_IDLE); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h4000_0000, 1'b1, lat, nrm, to);
    exp_q.push_back(32'h4000_0000);
    e = exp_q.pop_front();
    checks++; if (to || out_data !== e) $display("FAIL midop_restart_sum: got %h (to=%0b) want %h", out_data, to, e); else passed++;
    handshake();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_simple();
    test_cancel();
    test_norm_shift();
    test_overflow();
    test_underflow();
    test_zero_path();
    test_stall();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fp_product_accumulator.md
# fp_product_accumulator

Sequential IEEE-754 single-precision accumulator that sits directly downstream of the FP multiplier. It consumes a stream of 32-bit products over a valid/ready handshake and sums them with a multi-cycle align/add/normalize FSM. On the element flagged `in_last`, it emits the running sum over a second valid/ready handshake. Arithmetic style matches the multiplier: truncation (no rounding), no NaN/Inf/denormal semantics, and exponent field 0 treated as zero.

## Interface
- `ACC_INIT`, default `32'h0000_0000`: accumulator value after reset and after each emitted sum.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` and `in_last` are valid.
- `in_ready`  out  1: block can accept an element.
- `in_data`  in  32: FP product, `{sign, exp[7:0], man[22:0]}`.
- `in_last`  in  1: final element of the current sum.
- `out_valid`  out  1: `out_data` holds a completed sum.
- `out_ready`  in  1: consumer accepts `out_data`.
- `out_data`  out  32: accumulated sum.
- `out_overflow`  out  1: exponent overflow occurred anywhere in this sum; valid with `out_valid`.
- `out_underflow`  out  1: a result was flushed to zero in this sum; valid with `out_valid`.

## Operation
- States: IDLE, ALIGN, ADD, NORM, COMMIT, OUT.
- IDLE:
  - `in_ready=1`.
  - On `in_valid&&in_ready`, capture operand X and `last`, then go to ALIGN.
- ALIGN:
  - If X.exp==0, the result is the accumulator; go to COMMIT.
  - Else if acc.exp==0, the result is X; go to COMMIT.
  - Otherwise both mantissas become `{1,man}` (24 bits). Shift the smaller-exponent mantissa right by the exponent difference, discarding shifted-out bits. A difference of 24 or more gives 0.
  - Working exponent is the larger exponent, held in 9 bits. Go to ADD.
- ADD, on a 25-bit sum:
  - Equal signs: add; the sign is the common sign.
  - Differing signs: subtract the smaller magnitude from the larger. The sign is that of the larger magnitude; an exact tie gives +0.
  - If bit 24 is set, shift right 1 (truncate) and exp+1.
  - If exp ≥ 255, set the sticky overflow flag. Go to NORM.
- NORM, one action per cycle:
  - Mantissa zero: result is `32'h0`; go to COMMIT.
  - Bit 23 set: go to COMMIT.
  - Otherwise shift left 1 and exp−1. If exp reaches 0, the result is `32'h0`, set the sticky underflow flag, and go to COMMIT.
- COMMIT:
  - Write the result to acc.
  - If `last`, go to OUT; else go to IDLE.
- OUT:
  - `out_valid=1`; `out_data`/flags are stable until `out_ready`.
  - On handshake, acc←`ACC_INIT`, clear flags, go to IDLE.
- Overflow result:
  - Without `FP_ACC_SAT_EN`: exponent is the low 8 bits of the 9-bit value (wraps).
  - With `FP_ACC_SAT_EN`: see Configuration.

## Timing
- Reset values: state=IDLE, acc=`ACC_INIT`, `in_ready=1`, `out_valid=0`, `out_data=ACC_INIT`, `out_overflow=0`, `out_underflow=0`.
- Reset asserted mid-operation aborts immediately. The in-flight element and partial sum are discarded.
- Per element, with k = number of left shifts:
  - Normal path: accept (1) + ALIGN (1) + ADD (1) + NORM (k+1) + COMMIT (1) cycles. `in_ready` is high again in the cycle after COMMIT.
  - Zero-operand path: accept + ALIGN + COMMIT.
- Worst case k=23 gives 28 cycles per element.
- `in_ready` is low in every state except IDLE. Data presented while `in_ready=0` is not taken; the source must hold it.
- `out_data` updates on entry to OUT, one cycle after COMMIT. `out_valid` is high from that cycle until the cycle after the `out_ready` handshake.
- `out_valid` held with `out_ready=0` stalls the block indefinitely. `in_ready` stays 0 throughout.
- A single element with `in_last=1` produces `ACC_INIT`+X.

## Configuration
- `FP_ACC_SAT_EN` defined: when exp ≥ 255 after ADD, the result saturates to `{sign, 8'hFF, 23'h0}` (infinity) and NORM is bypassed. Subsequent elements still add, with the 255 exponent treated as a normal value.
- `FP_ACC_SAT_EN` undefined: the exponent wraps modulo 256 as described in Operation.
- `out_overflow` is reported identically in both builds.

## Test plan
- 0x3F800000 (1.0), then 0x40000000 (2.0, last) -> `out_data`=0x40400000, both flags 0.
- 0x3F800000, then 0xBF800000 (last) -> `out_data`=0x00000000.
- 0x3F800000, then 0xBF400000 (−0.75, last) -> `out_data`=0x3E800000. NORM takes exactly 3 cycles (k=2); second element accept-to-`in_ready` is 7 cycles.
- 0x7F7FFFFF twice (second last) -> `out_overflow`=1.
  - Without macro: `out_data`=0x7FFFFFFF.
  - With `FP_ACC_SAT_EN`: `out_data`=0x7F800000.
- Sum 1.0+2.0 with `out_ready` held 0 for 10 cycles -> `out_valid` and `out_data`=0x40400000 are stable for the full 10 cycles, and `in_ready`=0 throughout. After the handshake the next sum, 0x3F800000 (last) alone, gives 0x3F800000, confirming acc was cleared.
- `rst_n` pulsed low during ADD of the second element -> all outputs return to their reset values asynchronously. The next sum starts from `ACC_INIT`.
